// File: rtl/fanin_msg_tx.sv
// fanin_msg_tx
// Sending end of the fan-in link protocol. One message is framed as:
//   acquire token, my-ID, true next-ID, false next-ID, payload words, release.
// Tokens go out on a registered forward-token channel. The back-prop channel
// can stall (Nack) or abort (Term) the message.
//
// Optional build feature: define FANIN_MSG_TX_RETRY_EN to enable retry.
// The payload is then kept in a MAX_LEN-deep store. After a Term, the message
// is re-sent up to MAX_RETRY times.
//
// Token layouts (packed vectors):
//   O_FTk[WIDTH_DATA+2] v   token valid
//   O_FTk[WIDTH_DATA+1] a   acquire/release marker
//   O_FTk[WIDTH_DATA]   r   release marker
//   O_FTk[WIDTH_DATA-1:0] d token data
//   I_BTk[0] n (Nack, stall)   I_BTk[1] t (Term, abort)
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   I_Start             pulse: latch IDs and begin a message (IDLE only)
//   I_MyID/I_NextID_t/I_NextID_f  header IDs, latched on I_Start
//   I_Valid/I_Data/I_Last/O_Ready payload stream (word moves on I_Valid & O_Ready)
//   O_FTk               forward token (registered)
//   I_BTk               back-prop token
//   O_Busy              FSM not IDLE
//   O_Done / O_Abort    one-cycle end-of-message pulses
//   O_State             current FSM state (debug)
//
// Handshake: a forward token is taken by the link in every cycle where
// O_FTk.v & ~I_BTk.n. While Nack is high, O_FTk holds bit-exact.
module fanin_msg_tx #(
    parameter int WIDTH_DATA = 32,
    parameter int MAX_LEN    = 64,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Start,
    input  logic [WIDTH_DATA-1:0] I_MyID,
    input  logic [WIDTH_DATA-1:0] I_NextID_t,
    input  logic [WIDTH_DATA-1:0] I_NextID_f,
    input  logic                  I_Valid,
    input  logic [WIDTH_DATA-1:0] I_Data,
    input  logic                  I_Last,
    output logic                  O_Ready,
    output logic [WIDTH_DATA+2:0] O_FTk,
    input  logic [1:0]            I_BTk,
    output logic                  O_Busy,
    output logic                  O_Done,
    output logic                  O_Abort,
    output logic [2:0]            O_State
);

    localparam int FW = WIDTH_DATA + 3;
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [FW-1:0] RLS_TOK = {3'b111, {WIDTH_DATA{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACQ   = 3'd1,
        S_MY_ID = 3'd2,
        S_T_ID  = 3'd3,
        S_F_ID  = 3'd4,
        S_DATA  = 3'd5,
        S_RLS   = 3'd6
    } state_e;

    state_e                state_q, state_d;
    logic [FW-1:0]         ftk_q, ftk_d;
    logic [WIDTH_DATA-1:0] my_q, my_d, nt_q, nt_d, nf_q, nf_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;     // I_Last word is sitting on O_FTk
    logic                  abort_q, abort_d;   // current message ends as abort
    logic                  done_q, done_d;
    logic                  abortp_q, abortp_d;

    logic                  nack, term, accept, term_cut, full, can_take, take;
    logic                  src_valid, src_last, from_store;
    logic [WIDTH_DATA-1:0] src_data;

    assign nack     = I_BTk[0];
    assign term     = I_BTk[1];
    assign accept   = ftk_q[FW-1] & ~nack;
    // Term is honoured only while a message is in flight and not yet releasing.
    assign term_cut = term & (state_q != S_IDLE) & (state_q != S_RLS);
    assign full     = (cnt_q == CW'(MAX_LEN));
    // A payload word can be loaded when the output slot frees up this cycle.
    // F_ID is included so the first word follows the header without a bubble.
    assign can_take = ((state_q == S_F_ID) | (state_q == S_DATA)) & ~term & ~last_q & ~full
                    & (~nack | ~ftk_q[FW-1]);
    assign take     = can_take & src_valid;

`ifdef FANIN_MSG_TX_RETRY_EN
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [WIDTH_DATA-1:0] store_q [MAX_LEN];
    logic [CW-1:0]         stored_q, stored_d;  // words captured so far
    logic                  have_last_q, have_last_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  term_q, term_d;      // abort was caused by Term
    logic                  store_we;

    // On a re-send, words already captured are replayed from the store.
    // Words beyond that (Term hit before the payload finished) still come
    // from the input stream.
    assign from_store = (cnt_q < stored_q);
    assign src_valid  = from_store | I_Valid;
    assign src_data   = from_store ? store_q[cnt_q[IW-1:0]] : I_Data;
    assign src_last   = from_store ? (have_last_q && ((cnt_q + CW'(1)) == stored_q)) : I_Last;
    assign store_we   = take & ~from_store;
    assign O_Ready    = can_take & ~from_store;

    always_ff @(posedge clock) begin
        if (store_we) begin
            store_q[cnt_q[IW-1:0]] <= I_Data;
        end
    end
`else
    assign from_store = 1'b0;
    assign src_valid  = I_Valid;
    assign src_data   = I_Data;
    assign src_last   = I_Last;
    assign O_Ready    = can_take & ~from_store;
`endif

    always_comb begin
        state_d  = state_q;
        ftk_d    = ftk_q;
        my_d     = my_q;
        nt_d     = nt_q;
        nf_d     = nf_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        abort_d  = abort_q;
        done_d   = 1'b0;
        abortp_d = 1'b0;
`ifdef FANIN_MSG_TX_RETRY_EN
        stored_d    = stored_q;
        have_last_d = have_last_q;
        retry_d     = retry_q;
        term_d      = term_q;
        if (store_we) begin
            stored_d = stored_q + CW'(1);
            if (I_Last) have_last_d = 1'b1;
        end
`endif
        if (term_cut) begin
            // Abandon whatever is on the channel and release immediately.
            ftk_d   = RLS_TOK;
            state_d = S_RLS;
            abort_d = 1'b1;
`ifdef FANIN_MSG_TX_RETRY_EN
            term_d  = 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_Start) begin
                        my_d    = I_MyID;
                        nt_d    = I_NextID_t;
                        nf_d    = I_NextID_f;
                        ftk_d   = {3'b110, I_MyID};
                        state_d = S_ACQ;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        abort_d = 1'b0;
`ifdef FANIN_MSG_TX_RETRY_EN
                        stored_d    = '0;
                        have_last_d = 1'b0;
                        retry_d     = '0;
                        term_d      = 1'b0;
`endif
                    end
                end
                S_ACQ: if (accept) begin
                    ftk_d   = {3'b100, my_q};
                    state_d = S_MY_ID;
                end
                S_MY_ID: if (accept) begin
                    ftk_d   = {3'b100, nt_q};
                    state_d = S_T_ID;
                end
                S_T_ID: if (accept) begin
                    ftk_d   = {3'b100, nf_q};
                    state_d = S_F_ID;
                end
                S_F_ID, S_DATA: begin
                    if ((state_q == S_DATA) && accept && (last_q || full)) begin
                        // Final word (or MAX_LEN-th word without Last) has left.
                        ftk_d   = RLS_TOK;
                        state_d = S_RLS;
                        abort_d = ~last_q;
                    end else if (take) begin
                        ftk_d   = {3'b100, src_data};
                        cnt_d   = cnt_q + CW'(1);
                        last_d  = src_last;
                        state_d = S_DATA;
                    end else if (accept) begin
                        ftk_d   = '0;          // bubble
                        state_d = S_DATA;
                    end
                end
                S_RLS: begin
                    if (accept) begin
                        ftk_d   = '0;
                        state_d = S_IDLE;
                        if (abort_q) abortp_d = 1'b1;
                        else         done_d   = 1'b1;
`ifdef FANIN_MSG_TX_RETRY_EN
                        if (term_q && (retry_q < RW'(MAX_RETRY))) begin
                            ftk_d    = {3'b110, my_q};
                            state_d  = S_ACQ;
                            abortp_d = 1'b0;
                            retry_d  = retry_q + RW'(1);
                            cnt_d    = '0;
                            last_d   = 1'b0;
                            abort_d  = 1'b0;
                            term_d   = 1'b0;
                        end
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ftk_q    <= '0;
            my_q     <= '0;
            nt_q     <= '0;
            nf_q     <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
            abortp_q <= 1'b0;
`ifdef FANIN_MSG_TX_RETRY_EN
            stored_q    <= '0;
            have_last_q <= 1'b0;
            retry_q     <= '0;
            term_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ftk_q    <= ftk_d;
            my_q     <= my_d;
            nt_q     <= nt_d;
            nf_q     <= nf_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            abort_q  <= abort_d;
            done_q   <= done_d;
            abortp_q <= abortp_d;
`ifdef FANIN_MSG_TX_RETRY_EN
            stored_q    <= stored_d;
            have_last_q <= have_last_d;
            retry_q     <= retry_d;
            term_q      <= term_d;
`endif
        end
    end

    assign O_FTk   = ftk_q;
    assign O_Busy  = (state_q != S_IDLE);
    assign O_Done  = done_q;
    assign O_Abort = abortp_q;
    assign O_State = state_q;

endmodule

// File: tb/tb_fanin_msg_tx.sv
// Testbench for fanin_msg_tx (MAX_LEN=4, MAX_RETRY=1).
module tb_fanin_msg_tx;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          I_Start;
    logic [W-1:0]  I_MyID, I_NextID_t, I_NextID_f;
    logic          I_Valid;
    logic [W-1:0]  I_Data;
    logic          I_Last;
    logic          O_Ready;
    logic [W+2:0]  O_FTk;
    logic [1:0]    I_BTk;
    logic          O_Busy, O_Done, O_Abort;
    logic [2:0]    O_State;

    int n_checks = 0;
    int n_errors = 0;
    logic [W+2:0] exp_q[$];

    localparam logic [W+2:0] RLS_TOK = {3'b111, 32'h0};

    fanin_msg_tx #(.WIDTH_DATA(W), .MAX_LEN(4), .MAX_RETRY(1)) dut (
        .clock(clock), .reset(reset), .I_Start(I_Start),
        .I_MyID(I_MyID), .I_NextID_t(I_NextID_t), .I_NextID_f(I_NextID_f),
        .I_Valid(I_Valid), .I_Data(I_Data), .I_Last(I_Last), .O_Ready(O_Ready),
        .O_FTk(O_FTk), .I_BTk(I_BTk), .O_Busy(O_Busy), .O_Done(O_Done),
        .O_Abort(O_Abort), .O_State(O_State)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W+2:0] acq(input logic [W-1:0] d);
        return {3'b110, d};
    endfunction

    function automatic logic [W+2:0] hdr(input logic [W-1:0] d);
        return {3'b100, d};
    endfunction

    // Scoreboard: every token the link takes must match the next expected one.
    // Term cycles are not takes: the token on the channel is abandoned.
    always @(negedge clock) begin
        if (reset && O_FTk[W+2] && !I_BTk[0] && !I_BTk[1]) begin
            if (exp_q.size() == 0) check("tok_extra", O_FTk, '0);
            else                   check("tok_order", O_FTk, exp_q.pop_front());
        end
    end

    task automatic drained(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic watch(input string tag, input logic [W+2:0] tok);
        @(negedge clock);
        check(tag, O_FTk, tok);
    endtask

    task automatic start_msg(input logic [W-1:0] my, input logic [W-1:0] t, input logic [W-1:0] f);
        @(posedge clock); #1;
        I_Start = 1'b1; I_MyID = my; I_NextID_t = t; I_NextID_f = f;
        @(posedge clock); #1;
        I_Start = 1'b0;
    endtask

    // Offers words 0x11, 0x22, ... ; gives up quietly once the message is over.
    task automatic drive_words(input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            I_Valid = 1'b1;
            I_Data  = 32'(i + 1) * 32'h11;
            I_Last  = with_last && (i == n - 1);
            @(negedge clock);
            while (!O_Ready) begin
                if (!O_Busy || !reset) begin
                    I_Valid = 1'b0; I_Last = 1'b0;
                    return;
                end
                k++;
                if (k > 40) begin
                    check("ready_wait", O_Ready, 1);
                    I_Valid = 1'b0; I_Last = 1'b0;
                    return;
                end
                @(negedge clock);
            end
            @(posedge clock); #1;
        end
        I_Valid = 1'b0; I_Last = 1'b0;
    endtask

    task automatic push_hdr(input logic [W-1:0] my, input logic [W-1:0] t, input logic [W-1:0] f);
        exp_q.push_back(acq(my));
        exp_q.push_back(hdr(my));
        exp_q.push_back(hdr(t));
        exp_q.push_back(hdr(f));
    endtask

    // Two-word message without stalls; the tokens must leave back to back.
    task automatic run_basic(input logic [W-1:0] my, input logic [W-1:0] t, input logic [W-1:0] f);
        push_hdr(my, t, f);
        exp_q.push_back(hdr(32'h11));
        exp_q.push_back(hdr(32'h22));
        exp_q.push_back(RLS_TOK);
        start_msg(my, t, f);
        fork
            drive_words(2, 1'b1);
            begin
                watch("b_acq", acq(my));
                watch("b_my", hdr(my));
                watch("b_t", hdr(t));
                watch("b_f", hdr(f));
                watch("b_w0", hdr(32'h11));
                watch("b_w1", hdr(32'h22));
                watch("b_rls", RLS_TOK);
                check("b_done_lat", O_Done, 0);
                @(negedge clock);
                check("b_done", O_Done, 1);
                check("b_abort", O_Abort, 0);
                check("b_busy", O_Busy, 0);
            end
        join
        drained("b_drained");
    endtask

`ifdef FANIN_MSG_TX_RETRY_EN
    task automatic run_retry(input logic two_terms);
        push_hdr(32'h5, 32'h9, 32'hA);
        exp_q.push_back(hdr(32'h11));
        exp_q.push_back(RLS_TOK);
        push_hdr(32'h5, 32'h9, 32'hA);
        exp_q.push_back(hdr(32'h11));
        if (!two_terms) exp_q.push_back(hdr(32'h22));
        exp_q.push_back(RLS_TOK);
        start_msg(32'h5, 32'h9, 32'hA);
        fork
            drive_words(2, 1'b1);
            begin
                watch("r_acq", acq(32'h5));
                watch("r_my", hdr(32'h5));
                watch("r_t", hdr(32'h9));
                watch("r_f", hdr(32'hA));
                watch("r_w0", hdr(32'h11));
                @(posedge clock); #1; I_BTk = 2'b10;
                watch("r_w1", hdr(32'h22));
                @(posedge clock); #1; I_BTk = 2'b00;
                watch("r_rls1", RLS_TOK);
                watch("r_acq2", acq(32'h5));
                check("r_no_abort", O_Abort, 0);
                watch("r_my2", hdr(32'h5));
                watch("r_t2", hdr(32'h9));
                watch("r_f2", hdr(32'hA));
                check("r_replay_ready", O_Ready, 0);
                watch("r_w0b", hdr(32'h11));
                if (two_terms) begin
                    @(posedge clock); #1; I_BTk = 2'b10;
                end
                watch("r_w1b", hdr(32'h22));
                @(posedge clock); #1; I_BTk = 2'b00;
                watch("r_rls2", RLS_TOK);
                @(negedge clock);
                check("r_abort", O_Abort, two_terms);
                check("r_done", O_Done, !two_terms);
                check("r_busy", O_Busy, 0);
            end
        join
        drained("r_drained");
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; I_Start = 1'b0; I_MyID = '0; I_NextID_t = '0; I_NextID_f = '0;
        I_Valid = 1'b0; I_Data = '0; I_Last = 1'b0; I_BTk = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ftk", O_FTk, 0);
        check("rst_busy", O_Busy, 0);
        check("rst_ready", O_Ready, 0);
        check("rst_done", O_Done, 0);
        check("rst_abort", O_Abort, 0);
        check("rst_state", O_State, 0);
        @(posedge clock); #1; reset = 1'b1;

        // Term while idle has no effect.
        @(posedge clock); #1; I_BTk = 2'b10;
        @(negedge clock);
        check("idle_term_busy", O_Busy, 0);
        check("idle_term_ftk", O_FTk, 0);
        @(posedge clock); #1; I_BTk = 2'b00;

        // 1: basic message.
        run_basic(32'h5, 32'h9, 32'hA);
        repeat (2) @(posedge clock);

        // 2: Nack held 3 cycles on the T_ID token; Start while busy ignored.
        push_hdr(32'h5, 32'h9, 32'hA);
        exp_q.push_back(hdr(32'h11));
        exp_q.push_back(hdr(32'h22));
        exp_q.push_back(RLS_TOK);
        start_msg(32'h5, 32'h9, 32'hA);
        fork
            drive_words(2, 1'b1);
            begin
                watch("n_acq", acq(32'h5));
                watch("n_my", hdr(32'h5));
                @(posedge clock); #1;
                I_BTk = 2'b01; I_Start = 1'b1; I_MyID = 32'h77;
                watch("n_hold0", hdr(32'h9));
                @(posedge clock); #1; I_Start = 1'b0;
                watch("n_hold1", hdr(32'h9));
                check("n_ready", O_Ready, 0);
                watch("n_hold2", hdr(32'h9));
                @(posedge clock); #1; I_BTk = 2'b00;
                watch("n_hold3", hdr(32'h9));
                watch("n_f", hdr(32'hA));
                watch("n_w0", hdr(32'h11));
                watch("n_w1", hdr(32'h22));
                watch("n_rls", RLS_TOK);
                @(negedge clock);
                check("n_done", O_Done, 1);
            end
        join
        drained("n_drained");
        repeat (2) @(posedge clock);

        // 3: Term during the second of four data words.
        push_hdr(32'h5, 32'h9, 32'hA);
        exp_q.push_back(hdr(32'h11));
        exp_q.push_back(RLS_TOK);
        start_msg(32'h5, 32'h9, 32'hA);
        fork
            drive_words(4, 1'b1);
            begin
                repeat (5) @(negedge clock);
                @(posedge clock); #1; I_BTk = 2'b10;
                @(negedge clock);
                check("t_word2", O_FTk, hdr(32'h22));
                check("t_ready_term", O_Ready, 0);
                @(posedge clock); #1; I_BTk = 2'b00;
                @(negedge clock);
                check("t_rls", O_FTk, RLS_TOK);
                check("t_ready_rls", O_Ready, 0);
                @(negedge clock);
                check("t_abort", O_Abort, 1);
                check("t_done", O_Done, 0);
                check("t_state", O_State, 0);
            end
        join
        drained("t_drained");
        repeat (2) @(posedge clock);

        // 4: six words without Last against MAX_LEN=4.
        push_hdr(32'h5, 32'h9, 32'hA);
        exp_q.push_back(hdr(32'h11));
        exp_q.push_back(hdr(32'h22));
        exp_q.push_back(hdr(32'h33));
        exp_q.push_back(hdr(32'h44));
        exp_q.push_back(RLS_TOK);
        start_msg(32'h5, 32'h9, 32'hA);
        fork
            drive_words(6, 1'b0);
            begin
                repeat (7) @(negedge clock);
                watch("o_w3", hdr(32'h44));
                check("o_ready_full", O_Ready, 0);
                watch("o_rls", RLS_TOK);
                @(negedge clock);
                check("o_abort", O_Abort, 1);
                check("o_done", O_Done, 0);
            end
        join
        drained("o_drained");
        repeat (2) @(posedge clock);

        // 5: reset mid-DATA, then a clean message.
        push_hdr(32'h5, 32'h9, 32'hA);
        exp_q.push_back(hdr(32'h11));
        start_msg(32'h5, 32'h9, 32'hA);
        fork
            drive_words(4, 1'b1);
            begin
                repeat (4) @(negedge clock);
                watch("x_w0", hdr(32'h11));
                #2 reset = 1'b0;
                #1;
                check("x_ftk", O_FTk, 0);
                check("x_busy", O_Busy, 0);
                check("x_ready", O_Ready, 0);
            end
        join
        @(posedge clock); #1; reset = 1'b1;
        drained("x_drained");
        run_basic(32'h31, 32'h32, 32'h33);
        repeat (2) @(posedge clock);

`ifdef FANIN_MSG_TX_RETRY_EN
        // 6: retry; second Term exhausts MAX_RETRY=1, single Term recovers.
        run_retry(1'b1);
        repeat (2) @(posedge clock);
        run_retry(1'b0);
        repeat (2) @(posedge clock);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
